// File: rtl/crc5_frame_assembler_if.sv
// Message-in / codeword-out stream bundle for crc5_frame_assembler.
// The slave modport is the assembler; the master modport is whoever feeds and drains it.
interface crc5_frame_assembler_if #(
    parameter int N = 11,
    parameter int K = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_msg;
    logic             out_valid;
    logic             out_ready;
    logic [N+K-1:0]   out_frame;

    modport master (
        output in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_frame
    );

    modport slave (
        input  in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_frame
    );
endinterface

// File: rtl/crc5_frame_assembler.sv
// Feeds a fixed-latency CRC-5 engine, pairs each returned CRC with its delayed message and
// queues the codewords; optional delivered-frame counter under CRC_FRAME_STATS_EN.
module crc5_frame_assembler #(
    parameter int K     = 5,
    parameter int N     = 11,
    parameter int LAT   = 10,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    crc5_frame_assembler_if.slave bus,
    output logic [N+K-1:0]       crc_m_out,
    input  logic [K-1:0]         crc_in
`ifdef CRC_FRAME_STATS_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);
    localparam int FW = N + K;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);

    logic          acc;
    logic          capture;
    logic [N-1:0]  cap_msg;
    logic          pop;
    logic          fifo_nonempty;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [FW-1:0] entry [DEPTH];

    assign acc       = bus.in_valid & bus.in_ready;
    assign crc_m_out = acc ? {bus.in_msg, {K{1'b0}}} : '0;

    // Delay line tracks the engine pipeline stage-for-stage; it never stalls.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_dl
            logic         vld_q;
            logic [N-1:0] msg_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q <= 1'b0;
                        msg_q <= '0;
                    end else begin
                        vld_q <= acc;
                        msg_q <= acc ? bus.in_msg : '0;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q <= 1'b0;
                        msg_q <= '0;
                    end else begin
                        vld_q <= g_dl[gi-1].vld_q;
                        msg_q <= g_dl[gi-1].msg_q;
                    end
                end
            end
        end
    endgenerate

    assign capture = g_dl[LAT-1].vld_q;
    assign cap_msg = g_dl[LAT-1].msg_q;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [FW-1:0] entry_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (capture && (wr_ptr_q == PW'(gi))) begin
                    entry_q <= {cap_msg, crc_in};
                end
            end
            assign entry[gi] = entry_q;
        end
    endgenerate

    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign pop           = fifo_nonempty & bus.out_ready;

    assign bus.out_valid = fifo_nonempty;
    assign bus.out_frame = fifo_nonempty ? entry[rd_ptr_q] : '0;
    // Credits count buffered plus in-flight words, so a capture always finds a free slot.
    assign bus.in_ready  = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < CREDIT_LIMIT;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        inflight_d = inflight_q;
        if (capture) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        case ({capture, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({acc, capture})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef CRC_FRAME_STATS_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (pop && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
    assign frame_cnt = frame_cnt_q;
`endif

    a_no_full_capture: assert property (@(posedge clk) disable iff (rst)
        !(capture && (fifo_cnt_q == CNT_FULL)));

endmodule

// File: tb/tb_crc5_frame_assembler.sv
// Bench for crc5_frame_assembler: stands in for the CRC-5 engine and checks every cycle
// against a queue model of accepted messages and their visibility times.
module tb_crc5_frame_assembler;
    localparam int K     = 5;
    localparam int N     = 11;
    localparam int LAT   = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   crc_m_out;
    logic [4:0]    crc_in;
`ifdef CRC_FRAME_STATS_EN
    logic [15:0]   frame_cnt;
`endif

    crc5_frame_assembler_if #(.N(N), .K(K)) bus ();

    crc5_frame_assembler #(.K(K), .N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .crc_m_out (crc_m_out),
        .crc_in    (crc_in)
`ifdef CRC_FRAME_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Remainder of a 16-bit polynomial modulo x^5 + x^2 + 1.
    function automatic logic [4:0] poly_mod(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int b = 15; b >= 5; b--) begin
            if (r[b]) r = r ^ (16'h0025 << (b - 5));
        end
        return r[4:0];
    endfunction

    function automatic logic [15:0] ref_frame(input logic [10:0] m);
        return {m, poly_mod({m, 5'b00000})};
    endfunction

    // Stand-in CRC engine: LAT-stage pipeline sharing rst.
    logic [4:0] eng_q [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) eng_q[i] <= 5'd0;
        end else begin
            eng_q[0] <= poly_mod(crc_m_out);
            for (int i = 1; i < LAT; i++) eng_q[i] <= eng_q[i-1];
        end
    end
    assign crc_in = eng_q[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] frame;
        int          ts;
    } ent_t;
    ent_t mq[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_frame, s_crc_m;
    logic        e_ready, e_valid, acc_m, pop_m;
    logic [15:0] e_frame, e_crcm;
    int          popped = 0;
`ifdef CRC_FRAME_STATS_EN
    logic [15:0] s_fcnt;
    logic [15:0] e_fcnt = 16'd0;
`endif

    // One clock cycle: sample outputs, compute model expectations, drive inputs, update model.
    task automatic step(input logic v, input logic [10:0] m, input logic rdy);
        @(negedge clk);
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_out_frame = bus.out_frame;
`ifdef CRC_FRAME_STATS_EN
        s_fcnt      = frame_cnt;
`endif
        e_ready = (mq.size() < DEPTH);
        e_valid = (mq.size() > 0) && (cyc >= mq[0].ts + LAT + 1);
        e_frame = e_valid ? mq[0].frame : 16'h0000;
        bus.in_valid  = v;
        bus.in_msg    = m;
        bus.out_ready = rdy;
        acc_m  = v && e_ready;
        pop_m  = e_valid && rdy;
        e_crcm = acc_m ? {m, 5'b00000} : 16'h0000;
        #1;
        s_crc_m = crc_m_out;
        if (pop_m) begin
            $display("t=%0t pop frame=%h", $time, mq[0].frame);
            void'(mq.pop_front());
            popped++;
`ifdef CRC_FRAME_STATS_EN
            if (e_fcnt != 16'hFFFF) e_fcnt = e_fcnt + 16'd1;
`endif
        end
        if (acc_m) begin
            $display("t=%0t accept msg=%h", $time, m);
            mq.push_back('{frame: ref_frame(m), ts: cyc});
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_msg = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_checks++; if (bus.out_frame !== 16'h0000) begin n_fail++; $display("FAIL reset_out_frame got=%h exp=0000", bus.out_frame); end
        n_checks++; if (crc_m_out !== 16'h0000) begin n_fail++; $display("FAIL reset_crc_m_out got=%h exp=0000", crc_m_out); end
`ifdef CRC_FRAME_STATS_EN
        n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_frame_cnt got=%h exp=0000", frame_cnt); end
`endif
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_single();
        step(1'b1, 11'h400, 1'b1);
        n_checks++; if (s_crc_m !== 16'h8000) begin n_fail++; $display("FAIL single_crc_m got=%h exp=8000", s_crc_m); end
        for (int j = 1; j <= 12; j++) begin
            step(1'b0, 11'h000, 1'b1);
            n_checks++; if (s_out_valid !== (j == 11)) begin n_fail++; $display("FAIL single_valid j=%0d got=%b exp=%b", j, s_out_valid, (j == 11)); end
            if (j == 11) begin
                n_checks++; if (s_out_frame !== 16'h801F) begin n_fail++; $display("FAIL single_frame got=%h exp=801F", s_out_frame); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] msgs [3];
        logic [15:0] frames [3];
        msgs[0] = 11'h001; msgs[1] = 11'h000; msgs[2] = 11'h400;
        frames[0] = 16'h0025; frames[1] = 16'h0000; frames[2] = 16'h801F;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, msgs[i], 1'b1);
            n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready i=%0d got=%b exp=1", i, s_in_ready); end
        end
        for (int j = 1; j <= 12; j++) begin
            step(1'b0, 11'h000, 1'b1);
            n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_idle j=%0d got=%b exp=1", j, s_in_ready); end
            n_checks++; if (s_out_valid !== (j >= 9 && j <= 11)) begin n_fail++; $display("FAIL b2b_valid j=%0d got=%b exp=%b", j, s_out_valid, (j >= 9 && j <= 11)); end
            if (j >= 9 && j <= 11) begin
                n_checks++; if (s_out_frame !== frames[j-9]) begin n_fail++; $display("FAIL b2b_frame j=%0d got=%h exp=%h", j, s_out_frame, frames[j-9]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] m;
        logic [15:0] want [4];
        int nacc = 0;
        for (int i = 0; i < 20; i++) begin
            m = 11'($urandom);
            step(1'b1, m, 1'b0);
            n_checks++; if (s_in_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_in_ready i=%0d got=%b exp=%b", i, s_in_ready, (i < 4)); end
            if (acc_m) begin
                if (nacc < 4) want[nacc] = ref_frame(m);
                nacc++;
            end
        end
        n_checks++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got=%b exp=1", s_out_valid); end
        n_checks++; if (s_out_frame !== want[0]) begin n_fail++; $display("FAIL bp_hold_frame got=%h exp=%h", s_out_frame, want[0]); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 11'h000, 1'b1);
            n_checks++; if (s_in_ready !== (i != 0)) begin n_fail++; $display("FAIL bp_drain_ready i=%0d got=%b exp=%b", i, s_in_ready, (i != 0)); end
            n_checks++; if (s_out_valid !== (i < 4)) begin n_fail++; $display("FAIL bp_drain_valid i=%0d got=%b exp=%b", i, s_out_valid, (i < 4)); end
            if (i < 4) begin
                n_checks++; if (s_out_frame !== want[i]) begin n_fail++; $display("FAIL bp_drain_frame i=%0d got=%h exp=%h", i, s_out_frame, want[i]); end
            end
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int start_pop = popped;
        int guard = 0;
        while ((sent < 200 || mq.size() != 0) && guard < 6000) begin
            logic v, r;
            v = (sent < 200) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            r = (sent < 200) ? 1'($urandom_range(0, 4) > 1) : 1'b1;
            step(v, 11'($urandom), r);
            guard++;
            if (acc_m) sent++;
            n_checks++; if (s_in_ready !== e_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, s_in_ready, e_ready); end
            n_checks++; if (s_out_valid !== e_valid) begin n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, s_out_valid, e_valid); end
            n_checks++; if (s_out_frame !== e_frame) begin n_fail++; $display("FAIL rnd_out_frame cyc=%0d got=%h exp=%h", cyc, s_out_frame, e_frame); end
            n_checks++; if (s_crc_m !== e_crcm) begin n_fail++; $display("FAIL rnd_crc_m cyc=%0d got=%h exp=%h", cyc, s_crc_m, e_crcm); end
        end
        n_checks++; if (popped - start_pop != 200) begin n_fail++; $display("FAIL rnd_pop_count got=%0d exp=200", popped - start_pop); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] m;
        step(1'b1, 11'($urandom), 1'b0);
        step(1'b1, 11'($urandom), 1'b0);
        repeat (11) step(1'b0, 11'h000, 1'b0);
        step(1'b1, 11'($urandom), 1'b0);
        step(1'b1, 11'($urandom), 1'b0);
        step(1'b0, 11'h000, 1'b0);
        n_checks++; if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_reset valid=%b ready=%b exp valid=1 ready=0", s_out_valid, s_in_ready); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=1", bus.in_ready); end
        n_checks++; if (bus.out_frame !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_frame got=%h exp=0000", bus.out_frame); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        for (int j = 0; j < LAT + 4; j++) begin
            step(1'b0, 11'h000, 1'b1);
            n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid j=%0d got=%b exp=0", j, s_out_valid); end
        end
        m = 11'($urandom);
        step(1'b1, m, 1'b1);
        for (int j = 1; j <= LAT + 1; j++) step(1'b0, 11'h000, 1'b1);
        n_checks++; if (s_out_valid !== 1'b1 || s_out_frame !== ref_frame(m)) begin n_fail++; $display("FAIL mid_next_frame valid=%b got=%h exp=%h", s_out_valid, s_out_frame, ref_frame(m)); end
    endtask

`ifdef CRC_FRAME_STATS_EN
    task automatic test_stats();
        test_reset();
        e_fcnt = 16'd0;
        for (int i = 0; i < 5; i++) step(1'b1, 11'($urandom), 1'b1);
        repeat (LAT + 4) step(1'b0, 11'h000, 1'b1);
        n_checks++; if (s_fcnt !== 16'd5) begin n_fail++; $display("FAIL stats_five got=%0d exp=5", s_fcnt); end
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.frame_cnt_q;
        e_fcnt = 16'hFFFD;
        for (int i = 0; i < 3; i++) step(1'b1, 11'($urandom), 1'b1);
        repeat (LAT + 4) step(1'b0, 11'h000, 1'b1);
        n_checks++; if (s_fcnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate got=%h exp=FFFF", s_fcnt); end
        n_checks++; if (s_fcnt !== e_fcnt) begin n_fail++; $display("FAIL stats_model got=%h exp=%h", s_fcnt, e_fcnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef CRC_FRAME_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
